// File: rtl/scc_pkg.sv
// Shared decode definitions: instruction field positions, first-level
// decode encodings, the decoded bundle type and the field-extraction helper.
package scc_pkg;

   localparam int INSTR_BITS = 32;
   localparam int REG_BITS   = 3;
   localparam int NUM_REGS   = 8;

   localparam int FLD_HI      = 31;
   localparam int FLD_LO      = 30;
   localparam int SPECIAL_BIT = 29;
   localparam int SLD_HI      = 28;
   localparam int SLD_LO      = 25;
   localparam int ALU_OC_HI   = 24;
   localparam int ALU_OC_LO   = 22;
   localparam int B_COND_HI   = 24;
   localparam int B_COND_LO   = 21;
   localparam int DEST_HI     = 21;
   localparam int DEST_LO     = 19;
   localparam int OP_1_HI     = 18;
   localparam int OP_1_LO     = 16;
   localparam int OP_2_HI     = 15;
   localparam int OP_2_LO     = 13;
   localparam int IMM_HI      = 15;
   localparam int IMM_LO      = 0;

   // Only FLD_NO_WB marks an instruction that leaves the register file untouched.
   typedef enum logic [1:0] {
      FLD_0     = 2'b00,
      FLD_1     = 2'b01,
      FLD_2     = 2'b10,
      FLD_NO_WB = 2'b11
   } fld_e;

   typedef struct packed {
      fld_e                fld;
      logic                special;
      logic [3:0]          sld;
      logic [2:0]          alu_oc;
      logic [3:0]          b_cond;
      logic [REG_BITS-1:0] dest_reg;
      logic [REG_BITS-1:0] op_1_reg;
      logic [REG_BITS-1:0] op_2_reg;
      logic [15:0]         immediate;
   } bundle_t;

   function automatic bundle_t decode(input logic [INSTR_BITS-1:0] instr);
      bundle_t b;
      b.fld       = fld_e'(instr[FLD_HI:FLD_LO]);
      b.special   = instr[SPECIAL_BIT];
      b.sld       = instr[SLD_HI:SLD_LO];
      b.alu_oc    = instr[ALU_OC_HI:ALU_OC_LO];
      b.b_cond    = instr[B_COND_HI:B_COND_LO];
      b.dest_reg  = instr[DEST_HI:DEST_LO];
      b.op_1_reg  = instr[OP_1_HI:OP_1_LO];
      b.op_2_reg  = instr[OP_2_HI:OP_2_LO];
      b.immediate = instr[IMM_HI:IMM_LO];
      return b;
   endfunction

endpackage

// File: rtl/id_skid_buf.sv
// Two-entry (output + skid) elastic buffer for the decoded bundle; the
// upstream ready is a flop so it never depends combinationally on out_ready.
module id_skid_buf
   import scc_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    flush,
   input  logic    in_valid,
   input  bundle_t in_data,
   output logic    in_ready,
   output logic    out_valid,
   output bundle_t out_data,
   input  logic    out_ready
);

   logic    ready_q, ready_d;
   logic    out_valid_q, out_valid_d;
   logic    skid_valid_q, skid_valid_d;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    up, down;

   assign up   = in_valid && ready_q;
   assign down = out_valid_q && out_ready;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_d        = out_q;
      skid_d       = skid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || down) begin
         // Output slot frees up: the skid entry is older, so it goes first.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (up) begin
            out_d       = in_data;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (up) begin
         skid_d       = in_data;
         skid_valid_d = 1'b1;
      end
      ready_d = !skid_valid_d;
   end

   // NOTE: the data entries are reset as well because they drive visible outputs that must read 0 during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
         ready_q      <= ready_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_q        <= out_d;
         skid_q       <= skid_d;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q;

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode into a registered 2-entry bundle
// buffer, flag register, and an optional busy-register scoreboard (ID_SCOREBOARD_EN).
module id_stage
   import scc_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int REG_AW  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [INSTR_W-1:0] if_instr,
   output logic              if_ready,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [1:0]        fld,
   output logic              special,
   output logic [3:0]        sld,
   output logic [2:0]        alu_oc,
   output logic [3:0]        b_cond,
   output logic [REG_AW-1:0] dest_reg,
   output logic [REG_AW-1:0] pointer_reg,
   output logic [REG_AW-1:0] op_1_reg,
   output logic [REG_AW-1:0] op_2_reg,
   output logic [15:0]       immediate,
   output logic [15:0]       offset,
   output logic [3:0]        flags,
   input  logic              flush,
   input  logic [3:0]        flags_in,
   input  logic              flags_we,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_reg
);

   bundle_t dec_b;
   bundle_t out_b;
   logic    buf_valid;
   logic    buf_ready_dn;
   logic    stall;
   logic [3:0] flags_q;

   assign dec_b = decode(if_instr[INSTR_BITS-1:0]);

   id_skid_buf u_skid_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (if_valid),
      .in_data   (dec_b),
      .in_ready  (if_ready),
      .out_valid (buf_valid),
      .out_data  (out_b),
      .out_ready (buf_ready_dn)
   );

   // A stalled entry stays in the output slot and is retried every cycle.
   assign ex_valid     = buf_valid && !stall;
   assign buf_ready_dn = ex_ready && !stall;

`ifdef ID_SCOREBOARD_EN
   logic [NUM_REGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (ex_valid && ex_ready && (out_b.fld != FLD_NO_WB))
         busy_d[out_b.dest_reg] = 1'b1;
      // Applied last so a retire wins over an issue to the same register.
      if (wb_valid)
         busy_d[wb_reg] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign stall = busy_q[out_b.op_1_reg] || busy_q[out_b.op_2_reg];
`else
   logic unused_wb;
   assign unused_wb = ^{wb_valid, wb_reg};
   assign stall     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        flags_q <= '0;
      else if (flags_we) flags_q <= flags_in;
   end

   assign fld         = out_b.fld;
   assign special     = out_b.special;
   assign sld         = out_b.sld;
   assign alu_oc      = out_b.alu_oc;
   assign b_cond      = out_b.b_cond;
   assign dest_reg    = REG_AW'(out_b.dest_reg);
   assign pointer_reg = REG_AW'(out_b.op_1_reg);
   assign op_1_reg    = REG_AW'(out_b.op_1_reg);
   assign op_2_reg    = REG_AW'(out_b.op_2_reg);
   assign immediate   = out_b.immediate;
   assign offset      = out_b.immediate;
   assign flags       = flags_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, backpressure, flush,
// reset, flags and (when ID_SCOREBOARD_EN is defined) the register scoreboard.
module tb_id_stage;

   localparam int INSTR_W = 32;
   localparam int REG_AW  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_valid;
   logic [INSTR_W-1:0] if_instr;
   logic              if_ready;
   logic              ex_valid;
   logic              ex_ready;
   logic [1:0]        fld;
   logic              special;
   logic [3:0]        sld;
   logic [2:0]        alu_oc;
   logic [3:0]        b_cond;
   logic [REG_AW-1:0] dest_reg, pointer_reg, op_1_reg, op_2_reg;
   logic [15:0]       immediate, offset;
   logic [3:0]        flags;
   logic              flush;
   logic [3:0]        flags_in;
   logic              flags_we;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_reg;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   id_stage #(.INSTR_W(INSTR_W), .REG_AW(REG_AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_ready    (if_ready),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .fld         (fld),
      .special     (special),
      .sld         (sld),
      .alu_oc      (alu_oc),
      .b_cond      (b_cond),
      .dest_reg    (dest_reg),
      .pointer_reg (pointer_reg),
      .op_1_reg    (op_1_reg),
      .op_2_reg    (op_2_reg),
      .immediate   (immediate),
      .offset      (offset),
      .flags       (flags),
      .flush       (flush),
      .flags_in    (flags_in),
      .flags_we    (flags_we),
      .wb_valid    (wb_valid),
      .wb_reg      (wb_reg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_instr = '0;
      ex_ready = 1'b0;
      flush    = 1'b0;
      flags_in = '0;
      flags_we = 1'b0;
      wb_valid = 1'b0;
      wb_reg   = '0;

      // Reset state
      step();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_imm", 32'(immediate), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      rst_n = 1'b1;
      step();
      check("post_rst_if_ready", 32'(if_ready), 32'd1);
      check("post_rst_ex_valid", 32'(ex_valid), 32'd0);

      // Single instruction decode
      if_valid = 1'b1;
      if_instr = 32'h4A8B1234;
      ex_ready = 1'b1;
      step();
      if_valid = 1'b0;
      check("dec_ex_valid", 32'(ex_valid), 32'd1);
      check("dec_fld", 32'(fld), 32'd1);
      check("dec_special", 32'(special), 32'd0);
      check("dec_sld", 32'(sld), 32'd5);
      check("dec_alu_oc", 32'(alu_oc), 32'd2);
      check("dec_b_cond", 32'(b_cond), 32'd4);
      check("dec_dest", 32'(dest_reg), 32'd1);
      check("dec_op1", 32'(op_1_reg), 32'd3);
      check("dec_ptr", 32'(pointer_reg), 32'd3);
      check("dec_op2", 32'(op_2_reg), 32'd0);
      check("dec_imm", 32'(immediate), 32'h1234);
      check("dec_offset", 32'(offset), 32'h1234);
      step();
      check("empty_ex_valid", 32'(ex_valid), 32'd0);
      check("empty_hold_imm", 32'(immediate), 32'h1234);

      // Backpressure: three offers, two accepted, order preserved
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'hC0000001;
      step();
      check("bp1_ex_valid", 32'(ex_valid), 32'd1);
      check("bp1_imm", 32'(immediate), 32'h0001);
      check("bp1_if_ready", 32'(if_ready), 32'd1);
      if_instr = 32'hE0000002;
      step();
      check("bp2_if_ready", 32'(if_ready), 32'd0);
      check("bp2_imm", 32'(immediate), 32'h0001);
      if_instr = 32'hC0000003;
      step();
      check("bp3_if_ready", 32'(if_ready), 32'd0);
      check("bp3_imm", 32'(immediate), 32'h0001);
      check("bp3_special", 32'(special), 32'd0);
      if_valid = 1'b0;
      ex_ready = 1'b1;
      step();
      check("bp4_ex_valid", 32'(ex_valid), 32'd1);
      check("bp4_imm", 32'(immediate), 32'h0002);
      check("bp4_special", 32'(special), 32'd1);
      check("bp4_if_ready", 32'(if_ready), 32'd1);
      step();
      check("bp5_ex_valid", 32'(ex_valid), 32'd0);

      // Flush with both entries full and an offer pending; flags update alongside
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'hC0000011;
      step();
      if_instr = 32'hC0000012;
      step();
      check("fl_full_if_ready", 32'(if_ready), 32'd0);
      if_instr = 32'hC0000013;
      flush    = 1'b1;
      flags_we = 1'b1;
      flags_in = 4'b1010;
      step();
      flush    = 1'b0;
      flags_we = 1'b0;
      flags_in = 4'b0101;
      if_valid = 1'b0;
      ex_ready = 1'b1;
      check("fl_ex_valid", 32'(ex_valid), 32'd0);
      check("fl_if_ready", 32'(if_ready), 32'd1);
      check("fl_flags", 32'(flags), 32'hA);
      step();
      check("fl_dropped", 32'(ex_valid), 32'd0);
      check("flags_hold", 32'(flags), 32'hA);

      // Flush drops an upstream transfer that would otherwise be accepted
      if_valid = 1'b1;
      if_instr = 32'hC0000014;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      if_valid = 1'b0;
      check("fl_up_drop", 32'(ex_valid), 32'd0);

      // Reset asserted while a bundle is valid
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_instr = 32'hC0000021;
      step();
      if_valid = 1'b0;
      check("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
      check("mid_rst_if_ready", 32'(if_ready), 32'd0);
      check("mid_rst_imm", 32'(immediate), 32'd0);
      check("mid_rst_fld", 32'(fld), 32'd0);
      check("mid_rst_flags", 32'(flags), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("rel_if_ready", 32'(if_ready), 32'd1);
      check("rel_ex_valid", 32'(ex_valid), 32'd0);

      // Register dependency: writer of r2 followed by reader of r2
      ex_ready = 1'b1;
      if_valid = 1'b1;
      if_instr = 32'h00100005;
      step();
      check("dep_w_valid", 32'(ex_valid), 32'd1);
      check("dep_w_dest", 32'(dest_reg), 32'd2);
      if_instr = 32'h00020006;
      step();
      if_valid = 1'b0;
      check("dep_r_imm", 32'(immediate), 32'h0006);
`ifdef ID_SCOREBOARD_EN
      check("dep_stall1", 32'(ex_valid), 32'd0);
      step();
      check("dep_stall2", 32'(ex_valid), 32'd0);
      wb_valid = 1'b1;
      wb_reg   = 3'd2;
      step();
      wb_valid = 1'b0;
      check("dep_issue", 32'(ex_valid), 32'd1);
      check("dep_issue_op1", 32'(op_1_reg), 32'd2);
      step();
      check("dep_done", 32'(ex_valid), 32'd0);
`else
      check("nodep_issue", 32'(ex_valid), 32'd1);
      step();
      check("nodep_done", 32'(ex_valid), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter REG_AW, default 3, register-index width (8 registers).
REQ-003 SHALL have ports clk input 1 (rising-edge clock) and rst_n input 1 (asynchronous, active-low reset), listed first; one clock domain only.
REQ-004 SHALL have ports if_valid input 1 (instruction offered); if_instr input INSTR_W (instruction word); if_ready output 1 (stage accepts the offer).
REQ-005 SHALL have ports ex_valid output 1 (decoded bundle valid) and ex_ready input 1 (EX accepts the bundle).
REQ-006 SHALL have outputs fld 2 (first-level decode), special 1 (special encoding), sld 4 (second-level decode), alu_oc 3 (ALU opcode), b_cond 4 (branch condition), dest_reg REG_AW, pointer_reg REG_AW, op_1_reg REG_AW, op_2_reg REG_AW, immediate 16, offset 16, flags 4.
REQ-007 SHALL have inputs flush 1 (EX took a branch), flags_in 4 with flags_we 1 (flag update from EX), wb_valid 1 with wb_reg REG_AW (register writeback retire).

Function
REQ-008 SHALL decode the fields as fld=[31:30], special=[29], sld=[28:25], alu_oc=[24:22], dest_reg=[21:19], op_1_reg=pointer_reg=[18:16], op_2_reg=[15:13], b_cond=[24:21], immediate=offset=[15:0].
REQ-009 SHALL register all bundle outputs, giving 1-cycle latency from an accepted instruction to ex_valid when the buffer is empty.
REQ-010 SHALL hold a 2-entry buffer: an output entry and a skid entry; if_ready SHALL be a registered signal equal to "skid entry empty".
REQ-011 SHALL transfer upstream on if_valid&&if_ready and downstream on ex_valid&&ex_ready, both on the same edge when simultaneous.
REQ-012 SHALL hold every bundle output stable while ex_valid=1 and ex_ready=0.
REQ-013 SHALL, when the output entry advances and the skid entry is full, move the skid entry to the output entry next cycle, preserving program order.
REQ-014 SHALL drive ex_valid=0 and the bundle unchanged when the buffer is empty; no bubble is inserted when full and ex_ready=1.
REQ-015 SHALL, on flush=1, empty both entries at that edge, drop any concurrent upstream transfer, and drive ex_valid=0 next cycle; flush overrides all other events.
REQ-016 SHALL update the flags register from flags_in when flags_we=1, a 1-cycle-registered copy, independent of handshake and flush.

Reset
REQ-017 SHALL, while rst_n=0, drive ex_valid=0, if_ready=0, all bundle outputs and flags to 0, buffer empty, and scoreboard clear.
REQ-018 SHALL raise if_ready on the first clk edge after rst_n deasserts; a reset asserted mid-transfer SHALL discard both entries with no partial output.

Configuration
REQ-019 SHALL, with ID_SCOREBOARD_EN defined, keep an 8-bit busy vector: bit dest_reg set when an instruction with fld!=2'b11 (writes a register) transfers to EX; bit wb_reg cleared when wb_valid=1; clear has priority on the same register.
REQ-020 SHALL, with ID_SCOREBOARD_EN defined, hold ex_valid=0 while the output entry's op_1_reg or op_2_reg is busy and retry every cycle.
REQ-021 SHALL, with ID_SCOREBOARD_EN undefined, implement no busy vector, ignore wb_valid/wb_reg, and never stall on register dependencies.

Structure
REQ-022 SHALL place the field bit positions, the fld encodings and a bundle struct typedef in the shared package scc_pkg.
REQ-023 SHALL factor the 2-entry buffer into a sub-module id_skid_buf; decode and scoreboard logic stay in id_stage.

Verification
REQ-024 Single instruction 0x4A8B1234 with ex_ready=1 -> next cycle ex_valid=1, fld=1, special=0, sld=5, alu_oc=2, dest_reg=1, op_1_reg=3, op_2_reg=0, immediate=0x1234.
REQ-025 ex_ready=0 for 3 cycles while 3 instructions are offered -> 2 accepted, if_ready=0 after the 2nd, outputs stable; ex_ready=1 -> both are delivered in order on consecutive cycles.
REQ-026 flush=1 while both entries are full and if_valid=1 -> ex_valid=0 next cycle, the offered instruction is dropped, and if_ready=1.
REQ-027 rst_n pulsed low while ex_valid=1 -> all outputs are 0 immediately, and if_ready=1 one edge after release.
REQ-028 ID_SCOREBOARD_EN: instruction writing r2, then one reading op_1_reg=2 -> second is held with ex_valid=0 until wb_valid=1 and wb_reg=2, then it issues the following cycle.
REQ-029 flags_we=1 with flags_in=4'b1010 -> flags=4'b1010 next cycle, regardless of flush.
